alu_multicycle: RTL and testbench

//  Parametrised successor to the single-cycle datapath ALU. Executes ADD/SUB/AND/OR in one cycle.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_basic_core.sv | 49 ++++
 rtl/alu_multicycle.sv | 207 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op codes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_UMULL = 4'b0111;
  localparam logic [3:0] OP_UDIV  = 4'b1000;
  localparam logic [3:0] OP_SDIV  = 4'b1001;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Ops that run on the shared iterative engine; everything else completes in one cycle.
  function automatic logic is_iter_op(input logic [3:0] op);
    case (op)
      OP_MUL, OP_SMULL, OP_UMULL, OP_UDIV, OP_SDIV: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_basic_core.sv
// Combinational single-cycle ALU: ADD/SUB/AND/OR with NZCV; reserved codes give all zeros.
module alu_basic_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_c,
  output logic [3:0]       flags_c
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    sub      = (alu_control == OP_SUB);
    b_eff    = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub);
    result_c = '0;
    flags_c  = '0;
    case (alu_control)
      OP_ADD, OP_SUB: begin
        result_c        = sum[WIDTH-1:0];
        flags_c[FLAG_C] = sum[WIDTH];
        flags_c[FLAG_V] = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        flags_c[FLAG_N] = sum[WIDTH-1];
        flags_c[FLAG_Z] = (sum[WIDTH-1:0] == '0);
      end
      OP_AND: begin
        result_c        = a & b;
        flags_c[FLAG_N] = result_c[WIDTH-1];
        flags_c[FLAG_Z] = (result_c == '0);
      end
      OP_OR: begin
        result_c        = a | b;
        flags_c[FLAG_N] = result_c[WIDTH-1];
        flags_c[FLAG_Z] = (result_c == '0);
      end
      default: begin
        result_c = '0;
        flags_c  = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR plus a shared radix-2 engine for
// multiply and divide, with a start/busy/done handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultExtra,
  output logic [3:0]       ALUFlags
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t             state, next_state;
  logic [3:0]         op_q;
  logic               a_neg_q, b_neg_q;
  logic [WIDTH-1:0]   hi, lo, dv;
  logic [CNT_W-1:0]   cnt;

  logic               accept, load_iter, load_basic, calc_step, fix_step;
  logic               busy_d, done_d;

  logic [WIDTH-1:0]   basic_result;
  logic [3:0]         basic_flags;

  alu_basic_core #(.WIDTH(WIDTH)) u_basic (
    .alu_control (ALUControl),
    .a           (A),
    .b           (B),
    .result_c    (basic_result),
    .flags_c     (basic_flags)
  );

  // FSM state register; busy/done registered from the next-state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) next_state = is_iter_op(ALUControl) ? ST_CALC : ST_DONE;
        else       next_state = ST_IDLE;
      end
      ST_CALC: if (cnt == CNT_W'(WIDTH - 1)) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    accept     = 1'b0;
    load_iter  = 1'b0;
    load_basic = 1'b0;
    calc_step  = 1'b0;
    fix_step   = 1'b0;
    busy_d     = (next_state == ST_CALC) || (next_state == ST_FIX);
    done_d     = (next_state == ST_DONE);
    case (state)
      ST_IDLE, ST_DONE: begin
        accept     = start;
        load_iter  = start && is_iter_op(ALUControl);
        load_basic = start && !is_iter_op(ALUControl);
      end
      ST_CALC: calc_step = 1'b1;
      ST_FIX:  fix_step  = 1'b1;
      default: ;
    endcase
  end

  // Operand conditioning: signed ops run the engine on magnitudes
  logic             signed_in;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    signed_in = (ALUControl == OP_SMULL) || (ALUControl == OP_SDIV);
    a_mag     = (signed_in && A[WIDTH-1]) ? -A : A;
    b_mag     = (signed_in && B[WIDTH-1]) ? -B : B;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  logic             is_div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;

  always_comb begin
    is_div_q  = (op_q == OP_UDIV) || (op_q == OP_SDIV);
    mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? dv : '0)};
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, dv});
    div_diff  = div_shift[WIDTH-1:0] - dv;
    if (is_div_q) begin
      hi_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_step = {lo[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Sign correction and flag generation once the engine has finished
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_lo, fix_hi;
  logic [3:0]         fix_flags;

  always_comb begin
    prod = {hi, lo};
    if ((op_q == OP_SMULL) && (a_neg_q ^ b_neg_q)) prod = -prod;
    quo = lo;
    rem = hi;
    if (op_q == OP_SDIV) begin
      if (a_neg_q ^ b_neg_q) quo = -quo;
      if (a_neg_q)           rem = -rem;
    end
    // Divide by zero: remainder already equals the dividend; force quotient to 0
    if (dv == '0) quo = '0;
    fix_lo    = '0;
    fix_hi    = '0;
    fix_flags = '0;
    case (op_q)
      OP_MUL: begin
        fix_lo            = lo;
        fix_flags[FLAG_N] = lo[WIDTH-1];
        fix_flags[FLAG_Z] = (lo == '0);
      end
      OP_SMULL, OP_UMULL: begin
        fix_lo            = prod[WIDTH-1:0];
        fix_hi            = prod[2*WIDTH-1:WIDTH];
        fix_flags[FLAG_N] = prod[2*WIDTH-1];
        fix_flags[FLAG_Z] = (prod == '0);
      end
      OP_UDIV, OP_SDIV: begin
        fix_lo            = quo;
        fix_hi            = rem;
        fix_flags[FLAG_N] = quo[WIDTH-1];
        fix_flags[FLAG_Z] = (quo == '0);
      end
      default: ;
    endcase
    fix_flags[FLAG_C] = 1'b0;
    fix_flags[FLAG_V] = 1'b0;
  end

  // Engine registers and architectural outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      dv          <= '0;
      cnt         <= '0;
      Result      <= '0;
      ResultExtra <= '0;
      ALUFlags    <= '0;
    end else begin
      if (accept) op_q <= ALUControl;
      if (load_iter) begin
        a_neg_q <= signed_in && A[WIDTH-1];
        b_neg_q <= signed_in && B[WIDTH-1];
        hi      <= '0;
        lo      <= a_mag;
        dv      <= b_mag;
        cnt     <= '0;
      end else if (calc_step) begin
        hi  <= hi_step;
        lo  <= lo_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (load_basic) begin
        Result      <= basic_result;
        ResultExtra <= '0;
        ALUFlags    <= basic_flags;
      end else if (fix_step) begin
        Result      <= fix_lo;
        ResultExtra <= fix_hi;
        ALUFlags    <= fix_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle at WIDTH=32 with hand-computed expectations.
module tb_alu_multicycle;

  localparam int unsigned W = 32;

  logic         clk, reset, start;
  logic [3:0]   ALUControl;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] Result, ResultExtra;
  logic [3:0]   ALUFlags;

  int n_vec = 0;
  int n_err = 0;
  int excl_viol = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALUControl  (ALUControl),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Result      (Result),
    .ResultExtra (ResultExtra),
    .ALUFlags    (ALUFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) excl_viol++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op; lat = number of edges from accept to the done cycle (bounded)
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        output int lat);
    @(negedge clk);
    ALUControl = op; A = a_v; B = b_v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = '1; B = '1; ALUControl = 4'b0000;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] r, input logic [W-1:0] re,
                           input logic [3:0] fl);
    check({tag, "_R"},  64'(Result),      64'(r));
    check({tag, "_RE"}, 64'(ResultExtra), 64'(re));
    check({tag, "_F"},  64'(ALUFlags),    64'(fl));
  endtask

  initial begin
    int lat;
    int dones;
    int busy_bad;
    int done_at;

    reset = 1'b1; start = 1'b0; ALUControl = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_out("rst", 32'h0, 32'h0, 4'b0000);
    @(negedge clk); reset = 1'b0;

    run_op(4'b0000, 32'h7FFFFFFF, 32'h1, lat);
    check("add_lat", 64'(lat), 64'd1);
    check_out("add", 32'h80000000, 32'h0, 4'b1001);

    run_op(4'b0001, 32'd5, 32'd5, lat);
    check_out("sub", 32'h0, 32'h0, 4'b0110);

    run_op(4'b0010, 32'hF0F0F0F0, 32'h0FF00000, lat);
    check_out("and", 32'h00F00000, 32'h0, 4'b0000);

    run_op(4'b0011, 32'hF0000000, 32'h1, lat);
    check_out("or", 32'hF0000001, 32'h0, 4'b1000);

    run_op(4'b0110, 32'hFFFFFFFE, 32'd3, lat);
    check("smull_lat", 64'(lat), 64'd34);
    check_out("smull", 32'hFFFFFFFA, 32'hFFFFFFFF, 4'b1000);

    run_op(4'b0111, 32'hFFFFFFFE, 32'd3, lat);
    check_out("umull", 32'hFFFFFFFA, 32'h00000002, 4'b0000);

    run_op(4'b0100, 32'hFFFFFFFE, 32'd3, lat);
    check_out("mul", 32'hFFFFFFFA, 32'h0, 4'b1000);

    run_op(4'b1001, 32'hFFFFFFF9, 32'd2, lat);
    check_out("sdiv", 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000);

    run_op(4'b1000, 32'd100, 32'd7, lat);
    check("udiv_lat", 64'(lat), 64'd34);
    check_out("udiv", 32'd14, 32'd2, 4'b0000);

    run_op(4'b1000, 32'd9, 32'd0, lat);
    check("div0_lat", 64'(lat), 64'd34);
    check_out("div0", 32'h0, 32'd9, 4'b0100);

    run_op(4'b1001, 32'h80000000, 32'hFFFFFFFF, lat);
    check_out("sdiv_min", 32'h80000000, 32'h0, 4'b1000);

    run_op(4'b1001, 32'hFFFFFFF9, 32'd0, lat);
    check_out("sdiv0", 32'h0, 32'hFFFFFFF9, 4'b0100);

    run_op(4'b0101, 32'd3, 32'd4, lat);
    check("rsvd_lat", 64'(lat), 64'd1);
    check_out("rsvd", 32'h0, 32'h0, 4'b0000);

    // start pulses while busy are ignored
    @(negedge clk);
    ALUControl = 4'b1000; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; busy_bad = 0; done_at = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        dones++;
        if (done_at == 0) done_at = cyc;
      end
      if (cyc < 34 && !busy) busy_bad++;
      start = (cyc == 5 || cyc == 6 || cyc == 20);
      ALUControl = 4'b0000; A = 32'd1; B = 32'd1;
      if (cyc == 34) check_out("ign", 32'd14, 32'd2, 4'b0000);
      @(posedge clk); #1;
    end
    check("ign_dones", 64'(dones), 64'd1);
    check("ign_done_at", 64'(done_at), 64'd34);
    check("ign_busy", 64'(busy_bad), 64'd0);

    // reset during CALC abandons the op
    @(negedge clk);
    ALUControl = 4'b0111; A = 32'd1234; B = 32'd5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mid_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check_out("mid", 32'h0, 32'h0, 4'b0000);
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dones++; end
    check("mid_nodone", 64'(dones), 64'd0);
    run_op(4'b0000, 32'd1, 32'd1, lat);
    check("post_lat", 64'(lat), 64'd1);
    check("post_R", 64'(Result), 64'd2);

    // start held high through DONE: back-to-back accept
    @(negedge clk);
    ALUControl = 4'b0000; A = 32'd2; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    check("b2b_done1", 64'(done), 64'd1);
    check("b2b_R1", 64'(Result), 64'd5);
    ALUControl = 4'b1000; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done_lo", 64'(done), 64'd0);
    lat = 1;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    check("b2b_lat2", 64'(lat), 64'd34);
    check_out("b2b2", 32'd14, 32'd2, 4'b0000);

    check("busy_done_excl", 64'(excl_viol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
